// File: rtl/rshift_arbiter_pkg.sv
// Shared types and constants for the rshift_arbiter block.
// Optional left-rotate support is enabled by defining RSHIFT_ARB_LROT_EN.
package rshift_arb_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SHIFT_W = 3;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_e;

  // A left rotate by s equals a right rotate by (DATA_W - s) mod DATA_W.
  // The 3-bit wrap-around subtraction gives exactly that.
  function automatic logic [SHIFT_W-1:0] lrot_to_rrot(input logic [SHIFT_W-1:0] s);
    return SHIFT_W'(0) - s;
  endfunction

endpackage

// File: rtl/rshift_arbiter_if.sv
// Request and result channels of rshift_arbiter.
// The req_dir signal exists only when RSHIFT_ARB_LROT_EN is defined.
interface rshift_arbiter_if
  import rshift_arb_pkg::*;
#(
  parameter int unsigned N = 4
) ();

  localparam int unsigned ID_W = $clog2(N);

  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*DATA_W-1:0]  req_x;
  logic [N*SHIFT_W-1:0] req_shift;
`ifdef RSHIFT_ARB_LROT_EN
  logic [N-1:0]         req_dir;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_y;
  logic [ID_W-1:0]      out_id;

  // Requesters and result consumer side
  modport master (
`ifdef RSHIFT_ARB_LROT_EN
    output req_dir,
`endif
    output req_valid, req_x, req_shift, out_ready,
    input  req_ready, out_valid, out_y, out_id
  );

  // Arbiter side
  modport slave (
`ifdef RSHIFT_ARB_LROT_EN
    input  req_dir,
`endif
    input  req_valid, req_x, req_shift, out_ready,
    output req_ready, out_valid, out_y, out_id
  );

endinterface

// File: rtl/rshift_arbiter_rshift.sv
// Combinational 8-bit rotate-right datapath shared by all requesters.
module rshift
  import rshift_arb_pkg::*;
(
  input  logic [DATA_W-1:0]  x_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [DATA_W-1:0]  y_o
);

  logic [2*DATA_W-1:0] dbl;

  // Shifting a doubled copy brings the low bits around into the top bits.
  always_comb begin
    dbl = {x_i, x_i};
    y_o = DATA_W'(dbl >> shift_i);
  end

endmodule

// File: rtl/rshift_arbiter.sv
// Round-robin scheduler sharing one rotate-right datapath across N requesters.
// The result is registered on a single valid/ready channel and tagged with the winner ID.
// Defining RSHIFT_ARB_LROT_EN adds per-requester req_dir (1 = rotate left).
module rshift_arbiter
  import rshift_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic               clk,
  input  logic               rst,
  rshift_arbiter_if.slave    bus
);

  localparam int unsigned ID_W = $clog2(N);

  arb_state_e         state_q, state_d;
  logic [DATA_W-1:0]  y_q, y_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic               any_valid;
  logic [ID_W-1:0]    win;
  logic [DATA_W-1:0]  win_x;
  logic [SHIFT_W-1:0] win_shift;
  logic [SHIFT_W-1:0] rot_amt;
  logic [DATA_W-1:0]  rot_y;
  logic               accept;
  int unsigned        idx;
`ifdef RSHIFT_ARB_LROT_EN
  logic               win_dir;
`endif

  // Round-robin search starting at ptr_q; the winner's operands are muxed out here.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    win_x     = '0;
    win_shift = '0;
    idx       = 0;
`ifdef RSHIFT_ARB_LROT_EN
    win_dir   = 1'b0;
`endif
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        win       = ID_W'(idx);
        win_x     = bus.req_x[idx*DATA_W +: DATA_W];
        win_shift = bus.req_shift[idx*SHIFT_W +: SHIFT_W];
`ifdef RSHIFT_ARB_LROT_EN
        win_dir   = bus.req_dir[idx];
`endif
      end
    end
  end

  // Rotate amount fed to the shared right-rotator.
  always_comb begin
`ifdef RSHIFT_ARB_LROT_EN
    rot_amt = win_dir ? lrot_to_rrot(win_shift) : win_shift;
`else
    rot_amt = win_shift;
`endif
  end

  rshift u_rshift (
    .x_i     (win_x),
    .shift_i (rot_amt),
    .y_o     (rot_y)
  );

  // Grant only when the output register is free or being drained this cycle; never during reset.
  always_comb begin
    accept        = any_valid && ((state_q == IDLE) || bus.out_ready) && !rst;
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[win] = 1'b1;
    end
  end

  // Next-state and result-register load logic.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          state_d = HOLD;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      y_d   = rot_y;
      id_d  = win;
      ptr_d = (win == ID_W'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_y     = y_q;
  assign bus.out_id    = id_q;

endmodule
